// File: rtl/cam_capture_ctrl.sv
// Camera capture front end: samples an OV7670-style bus, decodes RGB565/555/444/Y to RGB332,
// decimates/crops and emits linear frame-RAM writes. Build macro CAPTURE_TESTPAT_EN adds colour-bar TEST_MODE.
module cam_capture_ctrl #(
  parameter int unsigned FRAME_W     = 176,
  parameter int unsigned FRAME_H     = 144,
  parameter int unsigned DECIM_X     = 1,
  parameter int unsigned DECIM_Y     = 1,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              CAM_PCLK,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  input  logic [7:0]        CAM_DATA,
  input  logic [1:0]        MODE,
  input  logic              ENABLE,
`ifdef CAPTURE_TESTPAT_EN
  input  logic              TEST_MODE,
`endif
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic              FRAME_DONE,
  output logic [7:0]        FRAME_CNT,
  output logic              LINE_ERR,
  output logic              BUSY
);

  localparam int unsigned LINE_PIX = FRAME_W * DECIM_X;
  localparam int unsigned PIX_W    = $clog2(LINE_PIX + 1);
  localparam int unsigned X_W      = $clog2(FRAME_W + 1);
  localparam int unsigned Y_W      = $clog2(FRAME_H + 1);
  localparam int unsigned DX_W     = (DECIM_X > 1) ? $clog2(DECIM_X) : 1;
  localparam int unsigned DY_W     = (DECIM_Y > 1) ? $clog2(DECIM_Y) : 1;

  localparam logic [PIX_W-1:0]  LINE_PIX_C = PIX_W'(LINE_PIX);
  localparam logic [X_W-1:0]    FRAME_W_C  = X_W'(FRAME_W);
  localparam logic [Y_W-1:0]    FRAME_H_C  = Y_W'(FRAME_H);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(FRAME_W);
  localparam logic [DX_W-1:0]   DX_RELOAD  = DX_W'(DECIM_X - 1);
  localparam logic [DY_W-1:0]   DY_RELOAD  = DY_W'(DECIM_Y - 1);

  localparam logic [1:0] MODE_565 = 2'b00;
  localparam logic [1:0] MODE_555 = 2'b01;
  localparam logic [1:0] MODE_444 = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LINE_WAIT, S_LINE, S_FRAME_END} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] pclk_sr, href_sr, vsync_sr;
  logic [7:0]             data_sr [SYNC_STAGES];
  logic                   pclk_prev, href_prev, vsync_prev;

  logic [1:0]        mode_q;
  logic              phase;
  logic [7:0]        hi_byte;
  logic [PIX_W-1:0]  pix_cnt;
  logic [DX_W-1:0]   x_dec;
  logic [DY_W-1:0]   y_dec;
  logic [X_W-1:0]    out_x;
  logic [Y_W-1:0]    out_y;
  logic [ADDR_W-1:0] line_base;

  logic       pclk_rise, href_cur, href_rise, href_fall, vsync_rise, vsync_fall;
  logic [7:0] data_cur;
  logic       frame_start, line_start, line_end, byte_take, pix_done;
  logic       line_full, line_kept, keep;
  logic [7:0] cam_rgb, pix_data;

  // Input synchronisers plus one history flop per control line for edge detection
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pclk_sr    <= '0;
      href_sr    <= '0;
      vsync_sr   <= '0;
      pclk_prev  <= 1'b0;
      href_prev  <= 1'b0;
      vsync_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sr[i] <= 8'h00;
    end else begin
      pclk_sr    <= {pclk_sr[SYNC_STAGES-2:0], CAM_PCLK};
      href_sr    <= {href_sr[SYNC_STAGES-2:0], CAM_HREF};
      vsync_sr   <= {vsync_sr[SYNC_STAGES-2:0], CAM_VSYNC};
      pclk_prev  <= pclk_sr[SYNC_STAGES-1];
      href_prev  <= href_sr[SYNC_STAGES-1];
      vsync_prev <= vsync_sr[SYNC_STAGES-1];
      data_sr[0] <= CAM_DATA;
      for (int i = 1; i < SYNC_STAGES; i++) data_sr[i] <= data_sr[i-1];
    end
  end

  assign href_cur   = href_sr[SYNC_STAGES-1];
  assign data_cur   = data_sr[SYNC_STAGES-1];
  assign pclk_rise  = pclk_sr[SYNC_STAGES-1] & ~pclk_prev;
  assign href_rise  = href_cur & ~href_prev;
  assign href_fall  = ~href_cur & href_prev;
  assign vsync_rise = vsync_sr[SYNC_STAGES-1] & ~vsync_prev;
  assign vsync_fall = ~vsync_sr[SYNC_STAGES-1] & vsync_prev;

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (vsync_fall && ENABLE) state_next = S_LINE_WAIT;
      S_LINE_WAIT: begin
        if (vsync_rise)     state_next = S_FRAME_END;
        else if (href_rise) state_next = S_LINE;
      end
      S_LINE:      if (href_fall) state_next = S_LINE_WAIT;
      S_FRAME_END: state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  assign frame_start = (state == S_IDLE) && (state_next == S_LINE_WAIT);
  assign line_start  = (state == S_LINE_WAIT) && (state_next == S_LINE);
  assign line_end    = (state == S_LINE) && href_fall;
  assign byte_take   = (state == S_LINE) && href_cur && pclk_rise;
  assign pix_done    = byte_take && phase;
  assign line_full   = (pix_cnt >= LINE_PIX_C);
  assign line_kept   = (y_dec == '0) && (out_y < FRAME_H_C);
  assign keep        = pix_done && !line_full && (x_dec == '0) && line_kept && (out_x < FRAME_W_C);

  function automatic logic [7:0] to_rgb332(input logic [1:0] mode, input logic [7:0] hi,
                                           input logic [7:0] lo);
    case (mode)
      MODE_565: to_rgb332 = {hi[7:5], hi[2:0], lo[4:3]};
      MODE_555: to_rgb332 = {hi[6:4], hi[1:0], lo[7], lo[4:3]};
      MODE_444: to_rgb332 = {hi[3:1], lo[7:5], lo[3:2]};
      default:  to_rgb332 = {hi[7:5], hi[7:5], hi[7:6]};
    endcase
  endfunction

  assign cam_rgb = to_rgb332(mode_q, hi_byte, data_cur);

`ifdef CAPTURE_TESTPAT_EN
  localparam int unsigned BAR_W  = (FRAME_W >= 8) ? FRAME_W / 8 : 1;
  localparam int unsigned BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);

  logic              test_q;
  logic [2:0]        bar_idx;
  logic [BAR_CW-1:0] bar_pos;

  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 8'hFF;
      3'd1:    bar_color = 8'hFC;
      3'd2:    bar_color = 8'h1F;
      3'd3:    bar_color = 8'h1C;
      3'd4:    bar_color = 8'hE3;
      3'd5:    bar_color = 8'hE0;
      3'd6:    bar_color = 8'h03;
      default: bar_color = 8'h00;
    endcase
  endfunction

  // Bar position follows kept output columns; a remainder past the eighth bar stays black
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      test_q  <= 1'b0;
      bar_idx <= 3'd0;
      bar_pos <= '0;
    end else begin
      if (frame_start) test_q <= TEST_MODE;
      if (line_start) begin
        bar_idx <= 3'd0;
        bar_pos <= '0;
      end else if (keep) begin
        if (bar_pos == BAR_LAST) begin
          bar_pos <= '0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_pos <= bar_pos + BAR_CW'(1);
        end
      end
    end
  end

  assign pix_data = test_q ? bar_color(bar_idx) : cam_rgb;
`else
  assign pix_data = cam_rgb;
`endif

  // Byte assembly, decimation/crop counters and registered outputs
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      mode_q     <= 2'b00;
      phase      <= 1'b0;
      hi_byte    <= 8'h00;
      pix_cnt    <= '0;
      x_dec      <= '0;
      y_dec      <= '0;
      out_x      <= '0;
      out_y      <= '0;
      line_base  <= '0;
      WR_EN      <= 1'b0;
      WR_ADDR    <= '0;
      WR_DATA    <= 8'h00;
      FRAME_DONE <= 1'b0;
      FRAME_CNT  <= 8'h00;
      LINE_ERR   <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      WR_EN      <= keep;
      FRAME_DONE <= (state_next == S_FRAME_END);
      BUSY       <= (state_next != S_IDLE);
      if (state_next == S_FRAME_END) FRAME_CNT <= FRAME_CNT + 8'd1;

      if (frame_start) begin
        mode_q    <= MODE;
        out_y     <= '0;
        y_dec     <= '0;
        line_base <= '0;
      end

      if (line_start) begin
        phase   <= 1'b0;
        pix_cnt <= '0;
        x_dec   <= '0;
        out_x   <= '0;
      end

      if (byte_take) begin
        phase <= ~phase;
        if (!phase) begin
          hi_byte <= data_cur;
        end else if (!line_full) begin
          pix_cnt <= pix_cnt + PIX_W'(1);
          x_dec   <= (x_dec == '0) ? DX_RELOAD : x_dec - DX_W'(1);
        end
      end

      if (pix_done && line_full) LINE_ERR <= 1'b1;

      if (keep) begin
        WR_ADDR <= line_base + ADDR_W'(out_x);
        WR_DATA <= pix_data;
        out_x   <= out_x + X_W'(1);
      end

      // Odd byte count leaves phase at 1 when HREF drops
      if (line_end) begin
        if (phase) LINE_ERR <= 1'b1;
        y_dec <= (y_dec == '0) ? DY_RELOAD : y_dec - DY_W'(1);
        if (line_kept) begin
          out_y     <= out_y + Y_W'(1);
          line_base <= line_base + ROW_STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: a 16x8 undecimated instance and an 8x4 instance
// decimating by 2 share one camera bus; RAM writes are collected and compared to expected frames.
module tb_cam_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pclk = 1'b0;
  logic       href = 1'b0;
  logic       vsync = 1'b1;
  logic [7:0] data = 8'h00;
  logic [1:0] mode = 2'b00;
  logic       enable = 1'b0;

  logic       a_wr_en, a_done_p, a_err, a_busy;
  logic [6:0] a_addr;
  logic [7:0] a_data, a_cnt;
  logic       b_wr_en, b_done_p, b_err, b_busy;
  logic [4:0] b_addr;
  logic [7:0] b_data, b_cnt;

  always #5 clk = ~clk;

  cam_capture_ctrl #(
    .FRAME_W(16), .FRAME_H(8), .DECIM_X(1), .DECIM_Y(1), .ADDR_W(7), .SYNC_STAGES(2)
  ) dut_a (
    .CLOCK(clk), .RESET(rst), .CAM_PCLK(pclk), .CAM_HREF(href), .CAM_VSYNC(vsync),
    .CAM_DATA(data), .MODE(mode), .ENABLE(enable),
    .WR_EN(a_wr_en), .WR_ADDR(a_addr), .WR_DATA(a_data), .FRAME_DONE(a_done_p),
    .FRAME_CNT(a_cnt), .LINE_ERR(a_err), .BUSY(a_busy)
  );

  cam_capture_ctrl #(
    .FRAME_W(8), .FRAME_H(4), .DECIM_X(2), .DECIM_Y(2), .ADDR_W(5), .SYNC_STAGES(3)
  ) dut_b (
    .CLOCK(clk), .RESET(rst), .CAM_PCLK(pclk), .CAM_HREF(href), .CAM_VSYNC(vsync),
    .CAM_DATA(data), .MODE(mode), .ENABLE(enable),
    .WR_EN(b_wr_en), .WR_ADDR(b_addr), .WR_DATA(b_data), .FRAME_DONE(b_done_p),
    .FRAME_CNT(b_cnt), .LINE_ERR(b_err), .BUSY(b_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int a_qa[$], a_qd[$], b_qa[$], b_qd[$];
  int a_done = 0, b_done = 0;
  int a_mark = 0;
  logic a_busy_seen, b_busy_seen;

  // Pattern source: 0 = constant hi/lo pair, 1 = pixel position encoded in RGB565
  int         pat_kind = 0;
  logic [7:0] c_hi = 8'h00, c_lo = 8'h00;

  always @(negedge clk) begin
    if (a_wr_en) begin a_qa.push_back(int'(a_addr)); a_qd.push_back(int'(a_data)); end
    if (b_wr_en) begin b_qa.push_back(int'(b_addr)); b_qd.push_back(int'(b_data)); end
    if (a_done_p) a_done++;
    if (b_done_p) b_done++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    a_qa.delete(); a_qd.delete(); b_qa.delete(); b_qd.delete();
    a_done = 0; b_done = 0;
  endtask

  // Expected RGB332 of camera pixel (r,c) under the position pattern decoded as RGB565
  function automatic int pos_rgb(input int r, input int c);
    logic [7:0] v;
    v = {3'(r), 3'(c), 1'(c >> 3), 1'b0};
    return int'(v);
  endfunction

  function automatic logic [7:0] byte_at(input int row, input int idx);
    int col;
    col = idx / 2;
    if (pat_kind == 1) begin
      if (idx % 2 == 0) return {3'(row), 2'b00, 3'(col)};
      else              return {3'b000, 1'(col >> 3), 4'b0000};
    end
    return (idx % 2 == 0) ? c_hi : c_lo;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_a_wr_en"},  int'(a_wr_en), 0);
    check({tag, "_a_addr"},   int'(a_addr), 0);
    check({tag, "_a_data"},   int'(a_data), 0);
    check({tag, "_a_done"},   int'(a_done_p), 0);
    check({tag, "_a_cnt"},    int'(a_cnt), 0);
    check({tag, "_a_err"},    int'(a_err), 0);
    check({tag, "_a_busy"},   int'(a_busy), 0);
    check({tag, "_b_wr_en"},  int'(b_wr_en), 0);
    check({tag, "_b_cnt"},    int'(b_cnt), 0);
    check({tag, "_b_busy"},   int'(b_busy), 0);
  endtask

  // One line of nbytes; rst_at >= 0 pulses RESET just before that byte and checks the outputs
  task automatic send_line(input int nbytes, input int row, input int rst_at);
    for (int i = 0; i < nbytes; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        tick(1);
        check_zero("mid_rst");
        a_mark = a_qa.size();
        rst = 1'b0;
      end
      data = byte_at(row, i);
      pclk = 1'b0;
      if (i == 0) href = 1'b1;
      tick(2);
      pclk = 1'b1;
      tick(2);
    end
    pclk = 1'b0;
    href = 1'b0;
    tick(3);
  endtask

  task automatic frame_open();
    vsync = 1'b0;
    tick(6);
    a_busy_seen = a_busy;
    b_busy_seen = b_busy;
  endtask

  task automatic frame_close();
    tick(2);
    vsync = 1'b1;
    tick(8);
  endtask

  task automatic send_frame(input int nlines, input int nbytes);
    frame_open();
    for (int r = 0; r < nlines; r++) send_line(nbytes, r, -1);
    frame_close();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
  endtask

  // Full position-pattern frame: A gets every pixel in raster order, B every other pixel/line
  task automatic check_full_frame(input string tag);
    int bad;
    check({tag, "_a_writes"}, a_qa.size(), 128);
    bad = 0;
    for (int i = 0; i < a_qa.size() && i < 128; i++)
      if (a_qa[i] != i || a_qd[i] != pos_rgb(i / 16, i % 16)) bad++;
    check({tag, "_a_bad_writes"}, bad, 0);
    check({tag, "_b_writes"}, b_qa.size(), 32);
    bad = 0;
    for (int i = 0; i < b_qa.size() && i < 32; i++)
      if (b_qa[i] != i || b_qd[i] != pos_rgb(2 * (i / 8), 2 * (i % 8))) bad++;
    check({tag, "_b_bad_writes"}, bad, 0);
    check({tag, "_a_done"}, a_done, 1);
    check({tag, "_b_done"}, b_done, 1);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int bad;
    vecs[0] = '{2'd0, 8'hF8, 8'h00, 8'hE0};
    vecs[1] = '{2'd0, 8'h07, 8'h18, 8'h1F};
    vecs[2] = '{2'd0, 8'hFF, 8'hFF, 8'hFF};
    vecs[3] = '{2'd1, 8'h7C, 8'h00, 8'hE0};
    vecs[4] = '{2'd1, 8'h03, 8'h80, 8'h1C};
    vecs[5] = '{2'd1, 8'h00, 8'h18, 8'h03};
    vecs[6] = '{2'd2, 8'h0F, 8'hF0, 8'hFC};
    vecs[7] = '{2'd2, 8'h0A, 8'h5C, 8'hAB};
    vecs[8] = '{2'd3, 8'hA5, 8'h00, 8'hB6};
    vecs[9] = '{2'd3, 8'hFF, 8'h00, 8'hFF};

    // Reset with random camera activity
    for (int i = 0; i < 3; i++) begin
      pclk  = 1'($urandom_range(0, 1));
      href  = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      data  = 8'($urandom);
      tick(1);
    end
    check_zero("reset");
    pclk = 1'b0; href = 1'b0; vsync = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    enable = 1'b1;

    // Conversion table: one single-pixel frame per vector
    pat_kind = 0;
    for (int v = 0; v < 10; v++) begin
      clear_mon();
      mode = vecs[v].mode; c_hi = vecs[v].hi; c_lo = vecs[v].lo;
      send_frame(1, 2);
      check($sformatf("vec%0d_a_writes", v), a_qa.size(), 1);
      if (a_qa.size() > 0) begin
        check($sformatf("vec%0d_a_addr", v), a_qa[0], 0);
        check($sformatf("vec%0d_a_data", v), a_qd[0], int'(vecs[v].exp));
      end
      if (b_qd.size() > 0) check($sformatf("vec%0d_b_data", v), b_qd[0], int'(vecs[v].exp));
      else check($sformatf("vec%0d_b_writes", v), 0, 1);
    end
    check("table_a_cnt", int'(a_cnt), 10);
    check("table_b_cnt", int'(b_cnt), 10);
    check("table_a_err", int'(a_err), 0);

    // Full frame, position-encoded RGB565
    clear_mon();
    mode = 2'd0; pat_kind = 1;
    send_frame(8, 32);
    check_full_frame("full");
    check("full_a_busy", int'(a_busy_seen), 1);
    check("full_b_busy", int'(b_busy_seen), 1);
    check("full_a_cnt", int'(a_cnt), 11);
    if (b_qd.size() > 8) begin
      check("b_addr8_row2", b_qd[8], pos_rgb(2, 0));
      check("b_addr1_col2", b_qd[1], pos_rgb(0, 2));
    end

    // MODE latched at frame start: change mid-frame has no effect until next frame
    clear_mon();
    mode = 2'd2; pat_kind = 0; c_hi = 8'h0F; c_lo = 8'hF0;
    frame_open();
    send_line(32, 0, -1);
    mode = 2'd0;
    send_line(32, 1, -1);
    frame_close();
    check("latch_a_writes", a_qa.size(), 32);
    bad = 0;
    foreach (a_qd[i]) if (a_qd[i] != 8'hFC) bad++;
    check("latch_a_bad_data", bad, 0);
    clear_mon();
    send_frame(1, 4);
    check("next_a_writes", a_qa.size(), 2);
    if (a_qd.size() > 1) check("next_a_data", a_qd[1], 8'h1E);

    // Overlong line (17 pixels) then odd-byte line
    clear_mon();
    pat_kind = 1;
    frame_open();
    send_line(34, 0, -1);
    check("long_a_writes", a_qa.size(), 16);
    check("long_b_writes", b_qa.size(), 8);
    check("long_a_err", int'(a_err), 1);
    check("long_b_err", int'(b_err), 1);
    send_line(31, 1, -1);
    frame_close();
    check("odd_a_writes", a_qa.size(), 31);
    bad = 0;
    foreach (a_qa[i]) if (a_qa[i] != i) bad++;
    check("odd_a_bad_addr", bad, 0);

    // Odd byte count alone sets the sticky error; it survives a clean frame
    do_reset();
    check("rst_a_err", int'(a_err), 0);
    clear_mon();
    send_frame(1, 3);
    check("odd_only_a_writes", a_qa.size(), 1);
    check("odd_only_a_err", int'(a_err), 1);
    clear_mon();
    send_frame(2, 8);
    check("clean_a_writes", a_qa.size(), 8);
    check("clean_a_err_sticky", int'(a_err), 1);
    check("clean_a_cnt", int'(a_cnt), 2);

    // Reset in the middle of a line: partial frame is abandoned
    clear_mon();
    frame_open();
    send_line(32, 0, -1);
    send_line(32, 1, -1);
    send_line(32, 2, 8);
    send_line(32, 3, -1);
    frame_close();
    check("after_rst_a_writes", a_qa.size() - a_mark, 0);
    check("after_rst_a_done", a_done, 0);
    check("after_rst_a_cnt", int'(a_cnt), 0);
    check("after_rst_b_cnt", int'(b_cnt), 0);
    clear_mon();
    send_frame(8, 32);
    check_full_frame("recover");
    check("recover_a_cnt", int'(a_cnt), 1);
    check("recover_b_cnt", int'(b_cnt), 1);

    // Frame with no lines still completes
    clear_mon();
    send_frame(0, 0);
    check("empty_a_done", a_done, 1);
    check("empty_a_writes", a_qa.size(), 0);
    check("empty_a_cnt", int'(a_cnt), 2);

    // ENABLE low at frame start: frame ignored
    clear_mon();
    enable = 1'b0;
    send_frame(1, 4);
    check("dis_a_busy", int'(a_busy_seen), 0);
    check("dis_a_writes", a_qa.size(), 0);
    check("dis_a_cnt", int'(a_cnt), 2);
    enable = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
